// File: rtl/coherence_bus_ctrl.sv
// -----------------------------------------------------------------------------
// coherence_bus_ctrl
//
// Memory-side responder for a two-core cache system. Each core has an
// icache/dcache pair. Instruction fetches, data reads, write-backs and MSI
// coherence transactions are arbitrated onto one single-ported RAM. On a
// coherence transaction the other core is snooped. A snooper that holds the
// block Modified supplies it directly to the requester, and RAM is updated
// from the same words at the same time.
//
// Ports
//   CLK, nRST                 clock, asynchronous active-low reset
//   iREN, iaddr               per-core instruction read request / word address
//   dREN, dWEN, daddr, dstore per-core data read / write request, address, data
//   cctrans, ccwrite          per-core coherence transaction / exclusive intent.
//                             When the core is the snooper, ccwrite means
//                             "I hold the block Modified".
//   iwait, dwait              per-core busy. Low only in the completing cycle.
//   iload, dload              per-core read data
//   ccwait, ccinv             snoop in progress / invalidate snooped block
//   ccsnoopaddr               address being snooped
//   ramREN, ramWEN            RAM read / write strobes (never both at once)
//   ramaddr, ramstore         RAM address / write data
//   ramload, ramstate         RAM read data / status (a word completes on ACCESS)
// -----------------------------------------------------------------------------
module coherence_bus_ctrl #(
    parameter int BLKWORDS = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [1:0]       iREN,
    input  logic [1:0][31:0] iaddr,
    input  logic [1:0]       dREN,
    input  logic [1:0]       dWEN,
    input  logic [1:0][31:0] daddr,
    input  logic [1:0][31:0] dstore,
    input  logic [1:0]       cctrans,
    input  logic [1:0]       ccwrite,
    output logic [1:0]       iwait,
    output logic [1:0]       dwait,
    output logic [1:0][31:0] iload,
    output logic [1:0][31:0] dload,
    output logic [1:0]       ccwait,
    output logic [1:0]       ccinv,
    output logic [1:0][31:0] ccsnoopaddr,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  logic [1:0]       ramstate
);

    localparam int CW = (BLKWORDS > 1) ? $clog2(BLKWORDS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(BLKWORDS - 1);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WB        = 3'd1,
        IFETCH    = 3'd2,
        SNOOP     = 3'd3,
        SNOOPRESP = 3'd4,
        UPG       = 3'd5,
        FWD       = 3'd6,
        RAMRD     = 3'd7
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic            g_r;
    logic            rr_r;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_s;

    logic            o_s;
    logic            access_s;
    logic            last_word_s;
    logic            grant_valid_s;
    logic            grant_core_s;
    state_t          grant_state_s;
    logic [1:0]      wb_req_s;

    // Winner within one request class. A tie goes to the round-robin core.
    function automatic logic pick_core(input logic [1:0] req, input logic rr);
        logic core;
        if (req == 2'b11) begin
            core = rr;
        end else begin
            core = req[1];
        end
        return core;
    endfunction

    assign o_s         = ~g_r;
    assign access_s    = (ramstate == RAM_ACCESS);
    assign last_word_s = access_s && (cnt_r == LAST_WORD);
    // A write with cctrans set is a supplier reply, not a write-back.
    assign wb_req_s    = dWEN & ~cctrans;

    // Priority grant: write-back over coherence over fetch.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_core_s  = 1'b0;
        grant_state_s = IDLE;
        if (|wb_req_s) begin
            grant_valid_s = 1'b1;
            grant_core_s  = pick_core(wb_req_s, rr_r);
            grant_state_s = WB;
        end else if (|cctrans) begin
            grant_valid_s = 1'b1;
            grant_core_s  = pick_core(cctrans, rr_r);
            grant_state_s = SNOOP;
        end else if (|iREN) begin
            grant_valid_s = 1'b1;
            grant_core_s  = pick_core(iREN, rr_r);
            grant_state_s = IFETCH;
        end else begin
            grant_valid_s = 1'b0;
        end
    end

    // State, granted core, round-robin pointer and word counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
            g_r     <= 1'b0;
            rr_r    <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if ((state_r == IDLE) && grant_valid_s) begin
                g_r  <= grant_core_s;
                rr_r <= ~grant_core_s;
            end
        end
    end

    // Next-state and next-counter logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    state_s = grant_state_s;
                end else begin
                    state_s = IDLE;
                end
            end
            WB: begin
                // Held while the owner keeps dWEN up, so the block is written atomically.
                if (!dWEN[g_r]) begin
                    state_s = IDLE;
                end else begin
                    state_s = WB;
                end
            end
            IFETCH: begin
                if (access_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = IFETCH;
                end
            end
            SNOOP: state_s = SNOOPRESP;
            SNOOPRESP: begin
                if (!dREN[g_r]) begin
                    state_s = UPG;
                end else if (cctrans[o_s] && ccwrite[o_s]) begin
                    state_s = FWD;
                end else begin
                    state_s = RAMRD;
                end
            end
            UPG: state_s = IDLE;
            FWD, RAMRD: begin
                // Only the counter ends a block. A dropped request cannot abort it.
                if (last_word_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = IDLE;
        endcase

        if (state_s == IDLE) begin
            cnt_s = '0;
        end else if (((state_r == FWD) || (state_r == RAMRD)) && access_s) begin
            if (cnt_r == LAST_WORD) begin
                cnt_s = '0;
            end else begin
                cnt_s = cnt_r + CW'(1);
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Cache-side and RAM-side outputs, decoded from the current state.
    always_comb begin
        iwait       = 2'b11;
        dwait       = 2'b11;
        ccwait      = 2'b00;
        ccinv       = 2'b00;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = 32'h0000_0000;
        ramstore    = 32'h0000_0000;
        iload       = {ramload, ramload};
        dload       = {ramload, ramload};
        case (state_r)
            IDLE: begin
                ramREN = 1'b0;
            end
            WB: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[g_r];
                ramstore = dstore[g_r];
                if (access_s) begin
                    dwait[g_r] = 1'b0;
                end else begin
                    dwait[g_r] = 1'b1;
                end
            end
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[g_r];
                if (access_s) begin
                    iwait[g_r] = 1'b0;
                end else begin
                    iwait[g_r] = 1'b1;
                end
            end
            SNOOP, SNOOPRESP: begin
                ccwait[o_s]      = 1'b1;
                ccsnoopaddr[o_s] = daddr[g_r];
                ccinv[o_s]       = ccwrite[g_r];
            end
            UPG: begin
                dwait[g_r] = 1'b0;
            end
            FWD: begin
                // The supplier's words go to the requester and RAM in the same cycle.
                ccwait[o_s] = 1'b1;
                ramWEN      = dWEN[o_s];
                ramaddr     = daddr[o_s];
                ramstore    = dstore[o_s];
                dload[g_r]  = dstore[o_s];
                if (access_s) begin
                    dwait = 2'b00;
                end else begin
                    dwait = 2'b11;
                end
            end
            RAMRD: begin
                ccwait[o_s] = 1'b1;
                ramREN      = 1'b1;
                ramaddr     = daddr[g_r];
                if (access_s) begin
                    dwait[g_r] = 1'b0;
                end else begin
                    dwait[g_r] = 1'b1;
                end
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_coherence_bus_ctrl
//
// Cycle-by-cycle vector table. Each row holds the inputs applied for one clock
// and the outputs expected during that clock. Completions (wait low) and RAM
// writes are also queued as expectations when a row is driven. They are popped
// when the DUT actually raises a completion or commits a RAM write.
// -----------------------------------------------------------------------------
module tb_coherence_bus_ctrl;

    localparam logic [1:0] RF = 2'd0;
    localparam logic [1:0] RB = 2'd1;
    localparam logic [1:0] RA = 2'd2;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [1:0]       iwait, dwait, ccwait, ccinv;
    logic [1:0][31:0] iload, dload, ccsnoopaddr;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;

    always #5 CLK = ~CLK;

    coherence_bus_ctrl #(.BLKWORDS(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .cctrans(cctrans), .ccwrite(ccwrite),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  iren, dren, dwen, cct, ccw;
        logic [31:0] ia0, ia1, da0, da1, ds0, ds1;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic [1:0]  e_iw, e_dw, e_ccw, e_inv;
        logic [31:0] e_sa0, e_sa1;
        logic        e_ren, e_wen;
        logic [31:0] e_ra, e_st;
        logic [1:0]  e_ci, e_cd;   // which completing core's load is data-checked
        logic [31:0] e_dat;
    } vec_t;

    typedef struct {
        logic        kind;   // 0 = instruction, 1 = data
        logic        core;
        logic        chk;
        logic [31:0] dat;
    } ld_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    vec_t rows[$];
    vec_t cur;
    ld_t  lq[$];
    wr_t  wq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input int r, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d actual=%0h required=%0h", nm, r, act, exp);
        end
    endtask

    task automatic st(input logic rst, input logic [1:0] iren, dren, dwen, cct, ccw,
                      input logic [31:0] ia0, ia1, da0, da1, ds0, ds1,
                      input logic [1:0] rs, input logic [31:0] rl);
        cur.rst = rst; cur.iren = iren; cur.dren = dren; cur.dwen = dwen;
        cur.cct = cct; cur.ccw = ccw;
        cur.ia0 = ia0; cur.ia1 = ia1; cur.da0 = da0; cur.da1 = da1;
        cur.ds0 = ds0; cur.ds1 = ds1; cur.rs = rs; cur.rl = rl;
    endtask

    task automatic ex(input logic [1:0] iw, dw, ccwt, inv, input logic [31:0] sa0, sa1,
                      input logic ren, wen, input logic [31:0] ra, stv,
                      input logic [1:0] ci, cd, input logic [31:0] dat);
        cur.e_iw = iw; cur.e_dw = dw; cur.e_ccw = ccwt; cur.e_inv = inv;
        cur.e_sa0 = sa0; cur.e_sa1 = sa1; cur.e_ren = ren; cur.e_wen = wen;
        cur.e_ra = ra; cur.e_st = stv; cur.e_ci = ci; cur.e_cd = cd; cur.e_dat = dat;
        rows.push_back(cur);
    endtask

    task automatic idle_ex();
        ex(2'b11, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0);
    endtask

    task automatic st_zero(input logic rst);
        st(rst, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, RF, 32'h0);
    endtask

    task automatic build_table();
        // Reset state
        st_zero(1'b0); idle_ex();
        st_zero(1'b0); idle_ex();
        // Fetch core0 at 0x40, two BUSY cycles then ACCESS
        st(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, RF, 32'h0); idle_ex();
        st(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, RB, 32'h0);
        ex(2'b11, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, RB, 32'h0);
        ex(2'b11, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, RA, 32'hDEADBEEF);
        ex(2'b10, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 2'b01, 2'b00, 32'hDEADBEEF);
        st_zero(1'b1); idle_ex();
        // Clean read miss, core1 at 0x100/0x104, core0 not a supplier
        st(1'b1, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0, RF, 32'h0); idle_ex();
        st(1'b1, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0, RF, 32'h0);
        ex(2'b11, 2'b11, 2'b01, 2'b00, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0, RF, 32'h0);
        ex(2'b11, 2'b11, 2'b01, 2'b00, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0, RB, 32'h0);
        ex(2'b11, 2'b11, 2'b01, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0, RA, 32'hA1);
        ex(2'b11, 2'b01, 2'b01, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 2'b00, 2'b10, 32'hA1);
        st(1'b1, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 32'h0, 32'h0, 32'h0, 32'h104, 32'h0, 32'h0, RA, 32'hA2);
        ex(2'b11, 2'b01, 2'b01, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0, 2'b00, 2'b10, 32'hA2);
        st_zero(1'b1); idle_ex();
        // Modified forward: core0 BusRdX at 0x200, core1 supplies 0x11/0x22
        st(1'b1, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 32'h0, 32'h0, 32'h200, 32'h0, 32'h0, 32'h0, RF, 32'h0); idle_ex();
        st(1'b1, 2'b00, 2'b01, 2'b00, 2'b11, 2'b11, 32'h0, 32'h0, 32'h200, 32'h0, 32'h0, 32'h0, RF, 32'h0);
        ex(2'b11, 2'b11, 2'b10, 2'b10, 32'h0, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b00, 2'b01, 2'b00, 2'b11, 2'b11, 32'h0, 32'h0, 32'h200, 32'h0, 32'h0, 32'h0, RF, 32'h0);
        ex(2'b11, 2'b11, 2'b10, 2'b10, 32'h0, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 32'h0, 32'h0, 32'h200, 32'h200, 32'h0, 32'h11, RB, 32'h55);
        ex(2'b11, 2'b11, 2'b10, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h200, 32'h11, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 32'h0, 32'h0, 32'h200, 32'h200, 32'h0, 32'h11, RA, 32'h55);
        ex(2'b11, 2'b00, 2'b10, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h200, 32'h11, 2'b00, 2'b01, 32'h11);
        st(1'b1, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 32'h0, 32'h0, 32'h200, 32'h204, 32'h0, 32'h22, RA, 32'h55);
        ex(2'b11, 2'b00, 2'b10, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h204, 32'h22, 2'b00, 2'b01, 32'h22);
        st_zero(1'b1); idle_ex();
        // Contention: write-back tie after reset, then a tie with rr=1, then write-back beats fetch
        st_zero(1'b0); idle_ex();
        st(1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 32'h300, 32'h400, 32'h31, 32'h41, RF, 32'h0); idle_ex();
        st(1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 32'h300, 32'h400, 32'h31, 32'h41, RA, 32'h0);
        ex(2'b11, 2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h300, 32'h31, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 32'h304, 32'h400, 32'h32, 32'h41, RA, 32'h0);
        ex(2'b11, 2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h304, 32'h32, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 32'h304, 32'h400, 32'h32, 32'h41, RF, 32'h0);
        ex(2'b11, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h304, 32'h32, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 32'h500, 32'h400, 32'h51, 32'h41, RF, 32'h0); idle_ex();
        st(1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 32'h500, 32'h400, 32'h51, 32'h41, RA, 32'h0);
        ex(2'b11, 2'b01, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h400, 32'h41, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 32'h500, 32'h404, 32'h51, 32'h42, RA, 32'h0);
        ex(2'b11, 2'b01, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h404, 32'h42, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 32'h0, 32'h600, 32'h500, 32'h404, 32'h51, 32'h42, RF, 32'h0);
        ex(2'b11, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h404, 32'h42, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 32'h0, 32'h600, 32'h500, 32'h0, 32'h51, 32'h0, RF, 32'h0); idle_ex();
        st(1'b1, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 32'h0, 32'h600, 32'h500, 32'h0, 32'h51, 32'h0, RA, 32'h0);
        ex(2'b11, 2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h500, 32'h51, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 32'h0, 32'h600, 32'h504, 32'h0, 32'h52, 32'h0, RA, 32'h0);
        ex(2'b11, 2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h504, 32'h52, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h600, 32'h504, 32'h0, 32'h52, 32'h0, RF, 32'h0);
        ex(2'b11, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h504, 32'h52, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h600, 32'h0, 32'h0, 32'h0, 32'h0, RF, 32'h0); idle_ex();
        st(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h600, 32'h0, 32'h0, 32'h0, 32'h0, RA, 32'h66);
        ex(2'b01, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0, 2'b10, 2'b00, 32'h66);
        st_zero(1'b1); idle_ex();
        // Upgrade: core1 cctrans+ccwrite without dREN, no RAM strobe
        st(1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 32'h0, 32'h0, 32'h0, 32'h700, 32'h0, 32'h0, RF, 32'h0); idle_ex();
        st(1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 32'h0, 32'h0, 32'h0, 32'h700, 32'h0, 32'h0, RF, 32'h0);
        ex(2'b11, 2'b11, 2'b01, 2'b01, 32'h700, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 32'h0, 32'h0, 32'h0, 32'h700, 32'h0, 32'h0, RF, 32'h0);
        ex(2'b11, 2'b11, 2'b01, 2'b01, 32'h700, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 32'h0, 32'h0, 32'h0, 32'h700, 32'h0, 32'h0, RF, 32'h0);
        ex(2'b11, 2'b01, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0);
        st_zero(1'b1); idle_ex();
        // Reset during word 1 of a forward, then a fresh fetch
        st(1'b1, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 32'h0, 32'h0, 32'h800, 32'h0, 32'h0, 32'h0, RF, 32'h0); idle_ex();
        st(1'b1, 2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 32'h0, 32'h0, 32'h800, 32'h0, 32'h0, 32'h0, RF, 32'h0);
        ex(2'b11, 2'b11, 2'b10, 2'b00, 32'h0, 32'h800, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 32'h0, 32'h0, 32'h800, 32'h0, 32'h0, 32'h0, RF, 32'h0);
        ex(2'b11, 2'b11, 2'b10, 2'b00, 32'h0, 32'h800, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0);
        st(1'b1, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 32'h0, 32'h0, 32'h800, 32'h800, 32'h0, 32'h81, RA, 32'h0);
        ex(2'b11, 2'b00, 2'b10, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h800, 32'h81, 2'b00, 2'b01, 32'h81);
        st(1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 32'h0, 32'h0, 32'h800, 32'h804, 32'h0, 32'h82, RA, 32'h0); idle_ex();
        st_zero(1'b0); idle_ex();
        st(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 32'h900, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, RF, 32'h0); idle_ex();
        st(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 32'h900, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, RA, 32'h99);
        ex(2'b10, 2'b11, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h900, 32'h0, 2'b01, 2'b00, 32'h99);
        st_zero(1'b1); idle_ex();
    endtask

    task automatic apply(input vec_t r);
        nRST      = r.rst;
        iREN      = r.iren;
        dREN      = r.dren;
        dWEN      = r.dwen;
        cctrans   = r.cct;
        ccwrite   = r.ccw;
        iaddr[0]  = r.ia0;
        iaddr[1]  = r.ia1;
        daddr[0]  = r.da0;
        daddr[1]  = r.da1;
        dstore[0] = r.ds0;
        dstore[1] = r.ds1;
        ramstate  = r.rs;
        ramload   = r.rl;
    endtask

    // Pop one expected completion and compare it with what the DUT finished.
    task automatic pop_done(input int r, input logic kind, input logic core, input logic [31:0] act);
        ld_t e;
        if (lq.size() == 0) begin
            check("done_unexpected", r, 64'(lq.size()), 64'd1);
        end else begin
            e = lq.pop_front();
            check("done_kind_core", r, {62'd0, kind, core}, {62'd0, e.kind, e.core});
            if (e.chk) begin
                check(kind ? "dload" : "iload", r, {32'd0, act}, {32'd0, e.dat});
            end
        end
    endtask

    initial begin
        vec_t r;
        wr_t  w;
        st_zero(1'b0);
        apply(cur);
        build_table();
        for (int i = 0; i < rows.size(); i++) begin
            r = rows[i];
            @(posedge CLK);
            #1;
            apply(r);
            for (int k = 0; k < 2; k++) begin
                if (r.e_iw[k] == 1'b0) lq.push_back('{1'b0, 1'(k), r.e_ci[k], r.e_dat});
                if (r.e_dw[k] == 1'b0) lq.push_back('{1'b1, 1'(k), r.e_cd[k], r.e_dat});
            end
            if (r.e_wen && (r.rs == RA)) wq.push_back('{r.e_ra, r.e_st});
            @(negedge CLK);
            check("iwait",       i, {62'd0, iwait},  {62'd0, r.e_iw});
            check("dwait",       i, {62'd0, dwait},  {62'd0, r.e_dw});
            check("ccwait",      i, {62'd0, ccwait}, {62'd0, r.e_ccw});
            check("ccinv",       i, {62'd0, ccinv},  {62'd0, r.e_inv});
            check("ccsnoopaddr", i, ccsnoopaddr,     {r.e_sa1, r.e_sa0});
            check("ramREN",      i, {63'd0, ramREN}, {63'd0, r.e_ren});
            check("ramWEN",      i, {63'd0, ramWEN}, {63'd0, r.e_wen});
            check("ramaddr",     i, {32'd0, ramaddr},  {32'd0, r.e_ra});
            check("ramstore",    i, {32'd0, ramstore}, {32'd0, r.e_st});
            for (int k = 0; k < 2; k++) begin
                if (iwait[k] === 1'b0) pop_done(i, 1'b0, 1'(k), iload[k]);
                if (dwait[k] === 1'b0) pop_done(i, 1'b1, 1'(k), dload[k]);
            end
            if ((ramWEN === 1'b1) && (ramstate == RA)) begin
                if (wq.size() == 0) begin
                    check("ramwrite_unexpected", i, 64'(wq.size()), 64'd1);
                end else begin
                    w = wq.pop_front();
                    check("ramwrite_addr", i, {32'd0, ramaddr},  {32'd0, w.a});
                    check("ramwrite_data", i, {32'd0, ramstore}, {32'd0, w.d});
                end
            end
        end
        check("done_queue_empty",  -1, 64'(lq.size()), 64'd0);
        check("write_queue_empty", -1, 64'(wq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coherence_bus_ctrl.md
# coherence_bus_ctrl

Memory-side responder for the two-core cache interface. It arbitrates instruction fetches, data reads, write-backs and coherence transactions from two cores' icache/dcache pairs onto one single-ported RAM. It also runs MSI snooping, which covers snoop broadcast, invalidation and cache-to-cache forwarding of Modified blocks. It drives all wait, load and snoop signals seen by each core's cache interface.

## Interface
- BLKWORDS, 2, words per dcache block; transfer counter width is clog2(BLKWORDS)
- CLK  in  1  system clock; all state on rising edge
- nRST  in  1  asynchronous, active-low reset
- iREN  in  [1:0]  per-core instruction read request
- iaddr  in  [1:0][31:0]  per-core instruction word address
- dREN, dWEN  in  [1:0] each  per-core data read / write request
- daddr, dstore  in  [1:0][31:0] each  per-core data word address / write data
- cctrans, ccwrite  in  [1:0] each  per-core coherence transaction / exclusive-intent (as requester); as snooper, ccwrite = "I hold it Modified"
- iwait, dwait  out  [1:0] each  1 = request not done; 0 for exactly the completing cycle
- iload, dload  out  [1:0][31:0] each  read data, valid when matching wait is 0
- ccwait  out  [1:0]  1 = core is being snooped, must not start new requests
- ccinv  out  [1:0]  invalidate snooped block
- ccsnoopaddr  out  [1:0][31:0]  address being snooped
- ramREN, ramWEN  out  1 each  RAM read / write strobe
- ramaddr, ramstore  out  32 each  RAM address / write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3; a word completes only when ramstate==ACCESS; ERROR is treated as BUSY

## Operation
- Registered: state, granted core g (other core o = ~g), word counter, round-robin pointer rr. Everything else is combinational.
- Defaults: iwait=dwait=2'b11, ccwait=ccinv=0, ccsnoopaddr=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
- iload[k]=dload[k]=ramload, except in FWD, where dload[g]=dstore[o].
- IDLE: pick the highest request class present on either core, in this order:
  - write-back (dWEN & ~cctrans)
  - coherence (cctrans)
  - fetch (iREN)
- Within a class, core rr wins a tie. Latch g, then go to WB, SNOOP or IFETCH. rr <= ~g on every grant.
- WB: ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g]. On ACCESS, dwait[g]=0. Stay in WB while dWEN[g]=1, so the block is atomic. Go to IDLE when dWEN[g] drops.
- IFETCH: ramREN=1, ramaddr=iaddr[g]. On ACCESS, iwait[g]=0, then go to IDLE.
- SNOOP (1 cycle): ccwait[o]=1, ccsnoopaddr[o]=daddr[g], ccinv[o]=ccwrite[g]. Go to SNOOPRESP.
- SNOOPRESP (1 cycle): same outputs as SNOOP. Sample the snooper's cctrans[o] & ccwrite[o] as "supplier", then branch:
  - dREN[g]=0 (upgrade): go to UPG.
  - supplier: go to FWD.
  - otherwise: go to RAMRD.
- UPG (1 cycle): dwait[g]=0, then IDLE.
- FWD: ccwait[o]=1. The supplier drives dWEN[o], daddr[o], dstore[o] word by word. Drive ramWEN=dWEN[o], ramaddr=daddr[o], ramstore=dstore[o], so RAM is updated concurrently. On ACCESS, dwait[o]=0 and dwait[g]=0 in the same cycle, and the counter increments. After BLKWORDS words, go to IDLE.
- RAMRD: ramREN=1, ramaddr=daddr[g]. On ACCESS, dwait[g]=0 and the counter increments. After BLKWORDS words, go to IDLE.
- Counter clears on every IDLE entry and wraps at BLKWORDS.
- ccwait[o] is held through SNOOP, SNOOPRESP, FWD and RAMRD. Core o's own requests are never granted until IDLE.

## Timing
- Grant decision takes 1 cycle in IDLE. RAM-limited latency after grant:
  - IFETCH: RAM latency.
  - RAMRD or FWD: 2 + BLKWORDS × RAM latency.
  - UPG: 3 cycles from request to dwait low.
- Only one ramREN/ramWEN is active per cycle. The two are never asserted simultaneously.
- Simultaneous write-back and fetch: write-back wins, and the fetch waits with iwait=1.
- Simultaneous coherence requests from both cores: rr core wins. The loser sees ccwait=1 while it is being snooped and is served afterward.
- A requester dropping its request mid-block is a protocol violation. The block stays in its state until the counter completes.
- nRST low, at any cycle including mid-transaction: state=IDLE, rr=0, counter=0, all outputs at defaults. No RAM strobe is asserted while in reset.

## Test plan
- Fetch: core0 iREN, iaddr=0x40; RAM returns 0xDEADBEEF after 2 BUSY cycles → iwait[0]=0 in the ACCESS cycle, iload[0]=0xDEADBEEF, then IDLE.
- Clean read miss: core1 dREN+cctrans, ccwrite=0, daddr=0x100/0x104; core0 not supplier → ccsnoopaddr[0]=0x100 with ccinv[0]=0 for 2 cycles; two RAM reads; dwait[1] low twice.
- Modified forward: core0 BusRdX at 0x200 (ccwrite=1); core1 asserts cctrans+ccwrite then dWEN with 0x11, 0x22 → ccinv[1]=1; dload[0]=0x11 then 0x22; RAM written at 0x200/0x204; dwait[0] and dwait[1] low together.
- Contention: both cores assert dWEN write-backs in the same cycle after reset → core0 is served first (whole block), then core1; rr alternates on the next tie.
- Upgrade: core1 cctrans+ccwrite, no dREN → ccinv[0]=1 for 2 cycles, dwait[1]=0 on the 3rd cycle, no RAM strobe.
- Reset mid-FWD: deassert nRST during word 1 → next cycle, all outputs are at defaults and state is IDLE; a fresh fetch after release completes normally.
